// File: rtl/fft_r2_seq_ctrl.sv
// In-place radix-2 DIT FFT sequencer: stage/butterfly walk, RAM read/write addressing, twiddle indices.
// Optional FFT_R2_SEQ_CTRL_SCALE_EN adds scale_o (per-write divide-by-2 request to the datapath).
module fft_r2_seq_ctrl #(
    parameter int unsigned N_LOG2 = 4,
    parameter int unsigned ADDR_W = N_LOG2,
    parameter int unsigned TW_W   = N_LOG2 - 1
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              start_i,
    output logic              busy_o,
    output logic              done_o,
    output logic [N_LOG2-1:0] stage_o,
    output logic              rd_en_o,
    output logic [ADDR_W-1:0] rd_addr_a_o,
    output logic [ADDR_W-1:0] rd_addr_b_o,
    output logic [TW_W-1:0]   twid_idx_o,
    output logic              wr_en_o,
    output logic [ADDR_W-1:0] wr_addr_a_o,
    output logic [ADDR_W-1:0] wr_addr_b_o
`ifdef FFT_R2_SEQ_CTRL_SCALE_EN
    ,
    output logic              scale_o
`endif
);

    localparam int unsigned HALF = 1 << (N_LOG2 - 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    logic [1:0]        state_q, state_d;
    logic [N_LOG2-1:0] s_q, s_d;
    logic [TW_W-1:0]   k_q, k_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [N_LOG2-1:0] stage_q, stage_d;
    logic              rd_en_q, rd_en_d;
    logic [ADDR_W-1:0] rd_addr_a_q, rd_addr_a_d;
    logic [ADDR_W-1:0] rd_addr_b_q, rd_addr_b_d;
    logic [TW_W-1:0]   twid_q, twid_d;
    logic              wr_en_q;
    logic [ADDR_W-1:0] wr_addr_a_q;
    logic [ADDR_W-1:0] wr_addr_b_q;

    logic [ADDR_W-1:0] k_ext, span, j_off, a_addr;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q     <= ST_IDLE;
            s_q         <= '0;
            k_q         <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            stage_q     <= '0;
            rd_en_q     <= 1'b0;
            rd_addr_a_q <= '0;
            rd_addr_b_q <= '0;
            twid_q      <= '0;
            wr_en_q     <= 1'b0;
            wr_addr_a_q <= '0;
            wr_addr_b_q <= '0;
        end else begin
            state_q     <= state_d;
            s_q         <= s_d;
            k_q         <= k_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            stage_q     <= stage_d;
            rd_en_q     <= rd_en_d;
            rd_addr_a_q <= rd_addr_a_d;
            rd_addr_b_q <= rd_addr_b_d;
            twid_q      <= twid_d;
            // Write-back trails the read by the one-cycle RAM/ROM latency
            wr_en_q     <= rd_en_q;
            wr_addr_a_q <= rd_addr_a_q;
            wr_addr_b_q <= rd_addr_b_q;
        end
    end

    // Next state; outputs are decoded from the next state so they register in step with it
    always_comb begin
        state_d     = state_q;
        s_d         = s_q;
        k_d         = k_q;
        busy_d      = 1'b0;
        done_d      = 1'b0;
        stage_d     = stage_q;
        rd_en_d     = 1'b0;
        rd_addr_a_d = '0;
        rd_addr_b_d = '0;
        twid_d      = '0;
        k_ext       = '0;
        span        = '0;
        j_off       = '0;
        a_addr      = '0;

        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    state_d = ST_RUN;
                    s_d     = '0;
                    k_d     = '0;
                end
            end
            ST_RUN: begin
                if (k_q == TW_W'(HALF - 1)) begin
                    state_d = ST_DRAIN;
                end else begin
                    k_d = k_q + TW_W'(1);
                end
            end
            ST_DRAIN: begin
                if (s_q < N_LOG2'(N_LOG2 - 1)) begin
                    s_d     = s_q + N_LOG2'(1);
                    k_d     = '0;
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d  = (state_d != ST_IDLE);
        done_d  = (state_d == ST_DONE);
        rd_en_d = (state_d == ST_RUN);
        stage_d = s_d;

        // Butterfly k of stage s: groups of 2*span, offset j inside the group
        if (rd_en_d) begin
            k_ext       = ADDR_W'(k_d);
            span        = ADDR_W'(1) << s_d;
            j_off       = k_ext & (span - ADDR_W'(1));
            a_addr      = ((k_ext >> s_d) << (s_d + N_LOG2'(1))) | j_off;
            rd_addr_a_d = a_addr;
            rd_addr_b_d = a_addr | span;
            twid_d      = TW_W'(j_off << (N_LOG2'(N_LOG2 - 1) - s_d));
        end
    end

    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign stage_o     = stage_q;
    assign rd_en_o     = rd_en_q;
    assign rd_addr_a_o = rd_addr_a_q;
    assign rd_addr_b_o = rd_addr_b_q;
    assign twid_idx_o  = twid_q;
    assign wr_en_o     = wr_en_q;
    assign wr_addr_a_o = wr_addr_a_q;
    assign wr_addr_b_o = wr_addr_b_q;
`ifdef FFT_R2_SEQ_CTRL_SCALE_EN
    assign scale_o     = wr_en_q;
`endif

endmodule

// File: tb/tb_fft_r2_seq_ctrl.sv
// Bench for fft_r2_seq_ctrl (N = 16): cycle-indexed reference model, random start traffic,
// mid-transform reset and an impulse run through a behavioural RAM/ROM/butterfly datapath.
module tb_fft_r2_seq_ctrl;

    localparam int N_LOG2 = 4;
    localparam int N      = 16;
    localparam int HALF   = N / 2;
    localparam int PER    = HALF + 1;
    localparam int TOTAL  = N_LOG2 * PER + 1;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       busy_o, done_o, rd_en_o, wr_en_o;
    logic [3:0] stage_o, rd_addr_a_o, rd_addr_b_o, wr_addr_a_o, wr_addr_b_o;
    logic [2:0] twid_idx_o;
`ifdef FFT_R2_SEQ_CTRL_SCALE_EN
    logic       scale_o;
`endif

    int checks = 0;
    int errors = 0;
    int t_m    = 0;
    bit chk_en   = 1'b0;
    bit idle_chk = 1'b0;
    bit load_req = 1'b0;

    always #5 clk = ~clk;

    fft_r2_seq_ctrl dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .start_i     (start),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .stage_o     (stage_o),
        .rd_en_o     (rd_en_o),
        .rd_addr_a_o (rd_addr_a_o),
        .rd_addr_b_o (rd_addr_b_o),
        .twid_idx_o  (twid_idx_o),
        .wr_en_o     (wr_en_o),
        .wr_addr_a_o (wr_addr_a_o),
        .wr_addr_b_o (wr_addr_b_o)
`ifdef FFT_R2_SEQ_CTRL_SCALE_EN
        ,
        .scale_o     (scale_o)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference addressing straight from the butterfly definition
    function automatic void bfly(input int s, input int k, output int a, output int b, output int tw);
        int span;
        span = 1 << s;
        a    = (k / span) * 2 * span + (k % span);
        b    = a + span;
        tw   = (k % span) * (1 << (N_LOG2 - 1 - s));
    endfunction

    // t = cycles since start accepted (0 = idle); each stage is HALF reads then one drain
    function automatic bit is_rd(input int t);
        return (t >= 1) && (t < TOTAL) && (((t - 1) % PER) < HALF);
    endfunction

    always @(posedge clk) begin
        if (!rst_n)            t_m <= 0;
        else if (t_m == 0)     t_m <= start ? 1 : 0;
        else if (t_m == TOTAL) t_m <= 0;
        else                   t_m <= t_m + 1;
    end

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        int a, b, tw;
        bit erd, ewr;
        if (chk_en) begin
            erd = is_rd(t_m);
            ewr = (t_m >= 2) && is_rd(t_m - 1);
            chk("busy", 32'(busy_o), 32'(t_m != 0));
            chk("done", 32'(done_o), 32'(t_m == TOTAL));
            chk("rd_en", 32'(rd_en_o), 32'(erd));
            chk("wr_en", 32'(wr_en_o), 32'(ewr));
            if (t_m >= 1 && t_m < TOTAL)
                chk("stage", 32'(stage_o), 32'((t_m - 1) / PER));
            if (erd) begin
                bfly((t_m - 1) / PER, (t_m - 1) % PER, a, b, tw);
                chk("rd_addr_a", 32'(rd_addr_a_o), 32'(a));
                chk("rd_addr_b", 32'(rd_addr_b_o), 32'(b));
                chk("twid", 32'(twid_idx_o), 32'(tw));
            end
            if (ewr) begin
                bfly((t_m - 2) / PER, (t_m - 2) % PER, a, b, tw);
                chk("wr_addr_a", 32'(wr_addr_a_o), 32'(a));
                chk("wr_addr_b", 32'(wr_addr_b_o), 32'(b));
            end
            if (rd_en_o && wr_en_o)
                chk("rd_wr_overlap", 32'(rd_addr_a_o == wr_addr_a_o || rd_addr_a_o == wr_addr_b_o ||
                                         rd_addr_b_o == wr_addr_a_o || rd_addr_b_o == wr_addr_b_o), 32'd0);
            if (idle_chk) begin
                chk("idle_stage", 32'(stage_o), 32'd0);
                chk("idle_addrs", 32'({rd_addr_a_o, rd_addr_b_o, wr_addr_a_o, wr_addr_b_o, twid_idx_o}), 32'd0);
            end
`ifdef FFT_R2_SEQ_CTRL_SCALE_EN
            chk("scale", 32'(scale_o), 32'(wr_en_o));
`endif
        end
    end

    // Behavioural datapath: sync RAM, twiddle ROM (W = cos - j sin, Q1.15), combinational butterfly
    logic signed [15:0] ram_re [N];
    logic signed [15:0] ram_im [N];
    logic signed [15:0] ra_re, ra_im, rb_re, rb_im, w_re, w_im;
    int tw_re [HALF] = '{32767, 30274, 23170, 12540, 0, -12540, -23170, -30274};
    int tw_im [HALF] = '{0, -12540, -23170, -30274, -32768, -30274, -23170, -12540};

    always @(posedge clk) begin
        longint pr, pi, ao_re, ao_im, bo_re, bo_im;
        if (load_req) begin
            for (int i = 0; i < N; i++) begin
                ram_re[i] <= (i == 0) ? 16'sh4000 : 16'sh0000;
                ram_im[i] <= 16'sh0000;
            end
        end else begin
            if (wr_en_o) begin
                pr    = (longint'(w_re) * rb_re - longint'(w_im) * rb_im) >>> 15;
                pi    = (longint'(w_re) * rb_im + longint'(w_im) * rb_re) >>> 15;
                ao_re = ra_re + pr;
                ao_im = ra_im + pi;
                bo_re = ra_re - pr;
                bo_im = ra_im - pi;
`ifdef FFT_R2_SEQ_CTRL_SCALE_EN
                ao_re = ao_re >>> 1;
                ao_im = ao_im >>> 1;
                bo_re = bo_re >>> 1;
                bo_im = bo_im >>> 1;
`endif
                ram_re[wr_addr_a_o] <= 16'(ao_re);
                ram_im[wr_addr_a_o] <= 16'(ao_im);
                ram_re[wr_addr_b_o] <= 16'(bo_re);
                ram_im[wr_addr_b_o] <= 16'(bo_im);
            end
            if (rd_en_o) begin
                ra_re <= ram_re[rd_addr_a_o];
                ra_im <= ram_im[rd_addr_a_o];
                rb_re <= ram_re[rd_addr_b_o];
                rb_im <= ram_im[rd_addr_b_o];
                w_re  <= 16'(tw_re[twid_idx_o]);
                w_im  <= 16'(tw_im[twid_idx_o]);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Counts cycles from the accept edge until done_o; n = 1 on entry
    task automatic run_to_done(output int n, output int wr_cnt);
        n = 1;
        wr_cnt = 0;
        while (!done_o && n < 100) begin
            if (wr_en_o) wr_cnt++;
            step();
            n++;
        end
        if (!done_o) chk("done_timeout", 32'(done_o), 32'd1);
    endtask

    initial begin
        int a, b, tw, n, wr_cnt;
        rst_n = 1'b0;
        start = 1'b0;

        // Model pins
        bfly(0, 7, a, b, tw);
        chk("pin_s0k7_a", 32'(a), 32'd14); chk("pin_s0k7_b", 32'(b), 32'd15); chk("pin_s0k7_tw", 32'(tw), 32'd0);
        bfly(1, 1, a, b, tw);
        chk("pin_s1k1_a", 32'(a), 32'd1); chk("pin_s1k1_b", 32'(b), 32'd3); chk("pin_s1k1_tw", 32'(tw), 32'd4);
        bfly(2, 3, a, b, tw);
        chk("pin_s2k3_a", 32'(a), 32'd3); chk("pin_s2k3_b", 32'(b), 32'd7); chk("pin_s2k3_tw", 32'(tw), 32'd6);
        bfly(3, 5, a, b, tw);
        chk("pin_s3k5_a", 32'(a), 32'd5); chk("pin_s3k5_b", 32'(b), 32'd13); chk("pin_s3k5_tw", 32'(tw), 32'd5);

        // Reset and idle
        step();
        chk_en   = 1'b1;
        idle_chk = 1'b1;
        step();
        step();
        rst_n = 1'b1;
        repeat (10) step();
        idle_chk = 1'b0;

        // Single transform: latency, write count, busy fall
        start = 1'b1;
        step();
        start = 1'b0;
        chk("first_rd_a", 32'(rd_addr_a_o), 32'd0);
        chk("first_rd_b", 32'(rd_addr_b_o), 32'd1);
        run_to_done(n, wr_cnt);
        chk("done_latency", 32'(n), 32'd37);
        chk("wr_count", 32'(wr_cnt), 32'd32);
        step();
        chk("busy_fall", 32'(busy_o), 32'd0);

        // start held high: ignored while busy, back-to-back restart from idle
        start = 1'b1;
        repeat (90) step();
        start = 1'b0;

        // Random start traffic
        for (int i = 0; i < 400; i++) begin
            start = ($urandom_range(0, 3) == 0);
            step();
        end
        start = 1'b0;
        n = 0;
        while (busy_o && n < 100) begin step(); n++; end
        chk("drain_idle", 32'(busy_o), 32'd0);

        // Reset mid-operation at stage 2, k = 4
        start = 1'b1;
        step();
        start = 1'b0;
        n = 0;
        while (t_m != 2 * PER + 5 && n < 100) begin step(); n++; end
        chk("mid_stage", 32'(stage_o), 32'd2);
        chk("mid_rd_a", 32'(rd_addr_a_o), 32'd8);
        chk("mid_rd_b", 32'(rd_addr_b_o), 32'd12);
        rst_n = 1'b0;
        step();
        chk("rst_rd_en", 32'(rd_en_o), 32'd0);
        chk("rst_wr_en", 32'(wr_en_o), 32'd0);
        chk("rst_busy", 32'(busy_o), 32'd0);
        rst_n = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        chk("restart_stage", 32'(stage_o), 32'd0);
        chk("restart_rd_a", 32'(rd_addr_a_o), 32'd0);
        chk("restart_rd_b", 32'(rd_addr_b_o), 32'd1);
        run_to_done(n, wr_cnt);
        step();

        // End-to-end impulse
        load_req = 1'b1;
        step();
        load_req = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        run_to_done(n, wr_cnt);
        step();
        for (int i = 0; i < N; i++) begin
`ifdef FFT_R2_SEQ_CTRL_SCALE_EN
            chk($sformatf("bin%0d_re", i), 32'(ram_re[i]), 32'h0400);
`else
            chk($sformatf("bin%0d_re", i), 32'(ram_re[i]), 32'h4000);
`endif
            chk($sformatf("bin%0d_im", i), 32'(ram_im[i]), 32'h0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
